// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled SCLK/CS_n/MOSI, MSB-first DATA_WIDTH-bit frames,
// one-entry transmit holding buffer and a valid/ready receive port.
module spi_target #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_clk_i,
  input  logic                  spi_cs_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  rx_overrun_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;

  state_t                 state_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic                   reload_pending_q;
  logic [DATA_WIDTH-1:0]  tx_shift_q, rx_shift_q;
  logic [DATA_WIDTH-1:0]  tx_buf_q;
  logic                   tx_full_q;
  logic [DATA_WIDTH-1:0]  rx_data_q;
  logic                   rx_valid_q, rx_overrun_q, tx_underrun_q, busy_q;

  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic                   tx_write, load_now;
  logic [DATA_WIDTH-1:0]  load_byte_d, rx_byte_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  // A byte load happens at frame start and on the falling edge after a completed byte;
  // CS deassertion takes priority over a coincident SCLK fall.
  assign load_now = ((state_q == IDLE) & cs_fall) |
                    ((state_q == SHIFT) & ~cs_rise & sclk_fall & reload_pending_q);
  // The load sees the buffer before any same-cycle write.
  assign load_byte_d = tx_full_q ? tx_buf_q : DEFAULT_TX;
  assign tx_write    = tx_valid_i & ~tx_full_q;
  assign rx_byte_d   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

  // Input synchronizers plus one extra stage for edge detection, idle levels on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  // Framing FSM with shift registers, tx holding buffer and rx handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      bit_cnt_q        <= '0;
      reload_pending_q <= 1'b0;
      tx_shift_q       <= '0;
      rx_shift_q       <= '0;
      tx_buf_q         <= '0;
      tx_full_q        <= 1'b0;
      rx_data_q        <= '0;
      rx_valid_q       <= 1'b0;
      rx_overrun_q     <= 1'b0;
      tx_underrun_q    <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;

      if (tx_write) begin
        tx_buf_q  <= tx_data_i;
        tx_full_q <= 1'b1;
      end else if (load_now) begin
        tx_full_q <= 1'b0;
      end

      if (load_now) begin
        tx_shift_q <= load_byte_d;
        if (!tx_full_q) tx_underrun_q <= 1'b1;
      end

      if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q          <= SHIFT;
            busy_q           <= 1'b1;
            bit_cnt_q        <= '0;
            reload_pending_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q          <= IDLE;
            busy_q           <= 1'b0;
            bit_cnt_q        <= '0;
            reload_pending_q <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_shift_q <= rx_byte_d;
              if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                bit_cnt_q        <= '0;
                rx_data_q        <= rx_byte_d;
                rx_valid_q       <= 1'b1;
                reload_pending_q <= 1'b1;
                if (rx_valid_q && !rx_ready_i) rx_overrun_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
            if (sclk_fall) begin
              if (reload_pending_q) reload_pending_q <= 1'b0;
              else tx_shift_q <= tx_shift_q << 1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_miso_o    = cs_s ? 1'b1 : tx_shift_q[DATA_WIDTH-1];
  assign spi_miso_oe_o = ~cs_s;
  assign tx_ready_o    = ~tx_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = rx_overrun_q;
  assign tx_underrun_o = tx_underrun_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_spi_target.sv
// Testbench for spi_target: vector table of single-byte frames, hand-written
// corner sequences and randomized frames checked against a transaction-level model.
module tb_spi_target;
  localparam int W  = 8;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         spi_clk = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0;
  logic         spi_miso, spi_miso_oe;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0, tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid, rx_ready = 1'b1;
  logic         rx_overrun, tx_underrun, busy;

  spi_target #(.DATA_WIDTH(W), .SYNC_STAGES(SS), .DEFAULT_TX(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_clk_i(spi_clk), .spi_cs_i(spi_cs), .spi_mosi_i(spi_mosi),
    .spi_miso_o(spi_miso), .spi_miso_oe_o(spi_miso_oe),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .rx_overrun_o(rx_overrun), .tx_underrun_o(tx_underrun), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int under_cnt = 0;
  int over_cnt = 0;
  int valid_cyc = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [W-1:0] rxq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: pulse counters, accepted rx bytes, time of each rx_valid rise.
  always @(negedge clk) begin
    if (tx_underrun) under_cnt <= under_cnt + 1;
    if (rx_overrun) over_cnt <= over_cnt + 1;
    if (rx_valid && rx_ready) rxq.push_back(rx_data);
    if (rx_valid && !prev_valid) valid_cyc <= cyc;
    prev_valid <= rx_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [W-1:0] v);
    tx_data = v; tx_valid = 1'b1;
    clk_wait(1);
    tx_valid = 1'b0;
  endtask

  task automatic start_frame(input int half);
    spi_cs = 1'b0;
    clk_wait(half);
  endtask

  task automatic end_frame();
    clk_wait(12);
  endtask

  // One byte as a mode-0 initiator. On the last byte of a frame CS rises together
  // with the final SCLK fall. An optional tx write is issued after the first rise.
  task automatic send_byte(input logic [W-1:0] m, input bit last, input int half,
                           input bit do_wr, input logic [W-1:0] wv,
                           output logic [W-1:0] miso_b, output logic rdy_seen);
    rdy_seen = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      spi_mosi = m[i];
      clk_wait(half);
      spi_clk = 1'b1;
      miso_b[i] = spi_miso;
      rise_cyc = cyc;
      if (i == W - 1 && do_wr) begin
        rdy_seen = tx_ready;
        tx_write(wv);
        clk_wait(half - 1);
      end else begin
        clk_wait(half);
      end
      spi_clk = 1'b0;
      if (i == 0 && last) spi_cs = 1'b1;
    end
  endtask

  typedef struct {
    logic         wr;
    logic [W-1:0] txb;
    logic [W-1:0] mosi;
    logic [W-1:0] exp_miso;
    logic [W-1:0] exp_rx;
    int           exp_under;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [W-1:0] mb, m, wv, exp_m, b0, b1;
    logic rdy;
    int u0, o0, n0, nb, half, exp_u;
    bit dw, model_full;
    logic [W-1:0] model_val;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
    vecs[1] = '{1'b0, 8'h00, 8'h81, 8'hFF, 8'h81, 1};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 0};
    vecs[3] = '{1'b1, 8'h7E, 8'h00, 8'h7E, 8'h00, 0};
    vecs[4] = '{1'b0, 8'h00, 8'h55, 8'hFF, 8'h55, 1};

    // Reset state
    rst_n = 1'b0;
    clk_wait(3);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_miso", spi_miso, 1);
    check("reset_miso_oe", spi_miso_oe, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    clk_wait(5);

    // Vector table: single-byte frames
    for (int k = 0; k < 5; k++) begin
      if (vecs[k].wr) begin
        check("vec_tx_ready_before_write", tx_ready, 1);
        tx_write(vecs[k].txb);
        check("vec_tx_ready_after_write", tx_ready, 0);
      end
      u0 = under_cnt; n0 = rxq.size();
      start_frame(5);
      send_byte(vecs[k].mosi, 1'b1, 5, 1'b0, '0, mb, rdy);
      end_frame();
      check("vec_miso", mb, vecs[k].exp_miso);
      check("vec_rx_latency", valid_cyc - rise_cyc, SS + 1);
      check("vec_underruns", under_cnt - u0, vecs[k].exp_under);
      check("vec_rx_count", rxq.size(), n0 + 1);
      if (rxq.size() > 0) check("vec_rx_data", rxq.pop_front(), vecs[k].exp_rx);
      check("vec_tx_ready_end", tx_ready, 1);
      check("vec_busy_end", busy, 0);
      $display("vector %0d: mosi=%02h miso=%02h", k, vecs[k].mosi, mb);
    end

    // Underrun with CS held low across two bytes
    u0 = under_cnt; rxq.delete();
    start_frame(5);
    send_byte(8'h01, 1'b0, 5, 1'b0, '0, b0, rdy);
    send_byte(8'h02, 1'b1, 5, 1'b0, '0, b1, rdy);
    end_frame();
    check("cont_miso0", b0, 8'hFF);
    check("cont_miso1", b1, 8'hFF);
    check("cont_underruns", under_cnt - u0, 2);
    check("cont_rx_count", rxq.size(), 2);
    if (rxq.size() == 2) begin
      check("cont_rx0", rxq.pop_front(), 8'h01);
      check("cont_rx1", rxq.pop_front(), 8'h02);
    end
    $display("continuous frame: miso=%02h,%02h", b0, b1);

    // Overrun with consumer stalled
    rx_ready = 1'b0; o0 = over_cnt;
    start_frame(5);
    check("frame_busy", busy, 1);
    check("frame_miso_oe", spi_miso_oe, 1);
    send_byte(8'h11, 1'b0, 5, 1'b0, '0, b0, rdy);
    send_byte(8'h22, 1'b1, 5, 1'b0, '0, b1, rdy);
    end_frame();
    check("ovr_pulses", over_cnt - o0, 1);
    check("ovr_rx_data", rx_data, 8'h22);
    check("ovr_rx_valid", rx_valid, 1);
    rx_ready = 1'b1;
    clk_wait(1);
    clk_wait(1);
    check("ovr_rx_valid_cleared", rx_valid, 0);
    check("ovr_rx_count", rxq.size(), 1);
    if (rxq.size() > 0) check("ovr_rx_accepted", rxq.pop_front(), 8'h22);
    $display("overrun frame: rx=%02h", rx_data);

    // Abort after 5 bits, then a clean frame
    n0 = rxq.size();
    spi_cs = 1'b0;
    clk_wait(5);
    for (int i = 0; i < 5; i++) begin
      spi_mosi = i[0];
      clk_wait(5); spi_clk = 1'b1;
      clk_wait(5); spi_clk = 1'b0;
    end
    clk_wait(5);
    spi_cs = 1'b1;
    end_frame();
    check("abort_busy", busy, 0);
    check("abort_rx_valid", rx_valid, 0);
    check("abort_rx_count", rxq.size(), n0);
    start_frame(5);
    send_byte(8'h5A, 1'b1, 5, 1'b0, '0, mb, rdy);
    end_frame();
    check("post_abort_rx_count", rxq.size(), n0 + 1);
    if (rxq.size() > 0) check("post_abort_rx", rxq.pop_front(), 8'h5A);
    $display("abort then frame: rx=5a expected");

    // tx write in the exact cycle the frame-start load acts
    u0 = under_cnt;
    spi_cs = 1'b0;
    clk_wait(SS);
    tx_data = 8'hC3; tx_valid = 1'b1;
    clk_wait(1);
    tx_valid = 1'b0;
    check("simul_tx_ready", tx_ready, 0);
    send_byte(8'h00, 1'b0, 5, 1'b0, '0, b0, rdy);
    send_byte(8'h00, 1'b1, 5, 1'b0, '0, b1, rdy);
    end_frame();
    rxq.delete();
    check("simul_miso0", b0, 8'hFF);
    check("simul_miso1", b1, 8'hC3);
    check("simul_underruns", under_cnt - u0, 1);
    check("simul_tx_ready_end", tx_ready, 1);
    $display("simultaneous write: miso=%02h,%02h", b0, b1);

    // Randomized frames against a transaction-level model of the holding buffer
    model_full = 1'b0; model_val = '0;
    for (int f = 0; f < 30; f++) begin
      nb = $urandom_range(1, 3);
      half = $urandom_range(4, 6);
      if ($urandom_range(0, 1) == 1) begin
        wv = W'($urandom);
        check("rand_idle_tx_ready", tx_ready, {31'b0, !model_full});
        tx_write(wv);
        if (!model_full) begin model_full = 1'b1; model_val = wv; end
      end
      u0 = under_cnt; exp_u = 0;
      start_frame(half);
      for (int b = 0; b < nb; b++) begin
        m = W'($urandom);
        dw = ($urandom_range(0, 1) == 1);
        wv = W'($urandom);
        exp_m = model_full ? model_val : 8'hFF;
        if (!model_full) exp_u++;
        model_full = 1'b0;
        send_byte(m, (b == nb - 1), half, dw, wv, mb, rdy);
        if (dw) begin
          check("rand_tx_ready", rdy, {31'b0, !model_full});
          if (!model_full) begin model_full = 1'b1; model_val = wv; end
        end
        check("rand_miso", mb, exp_m);
        check("rand_rx_latency", valid_cyc - rise_cyc, SS + 1);
        check("rand_rx_count", rxq.size(), 1);
        if (rxq.size() > 0) check("rand_rx", rxq.pop_front(), m);
        $display("random frame %0d byte %0d: mosi=%02h miso=%02h", f, b, m, mb);
      end
      end_frame();
      check("rand_underruns", under_cnt - u0, exp_u);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI responder (target) that answers the SoC's SPI initiator, for board-level loopback and for an MCU-to-MCU link.
- Mode 0 only (CPOL=0, CPHA=0), MSB first, fixed DATA_WIDTH-bit frames, one chip select.
- SCLK, CS_n and MOSI are oversampled by the system clock through synchronizers.
- Presents a one-entry transmit holding buffer and a valid/ready receive interface to the local bus side.

Parameters:
DATA_WIDTH, 8, frame and data width in bits (≥2)
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (≥2)
DEFAULT_TX, 8'hFF, byte shifted out when the transmit buffer is empty at byte load (width DATA_WIDTH)

Ports:
clk  input  1  system clock, the only clock domain
rst_n  input  1  reset, synchronous, active-low
spi_clk_i  input  1  SCLK from initiator, asynchronous
spi_cs_i  input  1  chip select from initiator, active-low, asynchronous
spi_mosi_i  input  1  serial data in, asynchronous
spi_miso_o  output  1  serial data out
spi_miso_oe_o  output  1  MISO output enable, high while selected
tx_data_i  input  DATA_WIDTH  byte to send
tx_valid_i  input  1  tx_data_i valid
tx_ready_o  output  1  transmit buffer empty; write accepted when tx_valid_i & tx_ready_o
rx_data_o  output  DATA_WIDTH  last received byte
rx_valid_o  output  1  rx_data_o holds an unread byte
rx_ready_i  input  1  consumer accepts rx_data_o
rx_overrun_o  output  1  one-cycle pulse: byte completed while rx_valid_o was high
tx_underrun_o  output  1  one-cycle pulse: DEFAULT_TX loaded because buffer was empty
busy_o  output  1  high in SHIFT state

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0 except spi_miso_o=1 and tx_ready_o=1. State IDLE, bit_cnt=0, synchronizers filled with idle levels (SCLK 0, CS 1, MOSI 0).
- Synchronize each SPI input; sync_q is the last synchronizer stage, prev_q is one more register. Events are combinational: sclk_rise = sync_q & ~prev_q, sclk_fall = ~sync_q & prev_q, cs_fall, cs_rise. Every event acts on the next clk edge.
- Pin-to-action latency: SYNC_STAGES+1 clk cycles. Required SCLK period ≥ 8 clk cycles; high and low phases each ≥ 4 clk cycles.
- IDLE: on cs_fall go to SHIFT.
  - Load tx_shift from the buffer if it is full, and the buffer empties (tx_ready_o=1).
  - Otherwise load DEFAULT_TX and pulse tx_underrun_o.
  - bit_cnt=0.
- SHIFT, on sclk_rise:
  - rx_shift <= {rx_shift[W-2:0], mosi_sync}; bit_cnt++.
  - If bit_cnt was W-1: rx_data_o <= the completed byte; rx_valid_o <= 1; bit_cnt <= 0; set reload_pending.
  - If rx_valid_o was already 1 and rx_ready_i is low in that cycle: overwrite rx_data_o and pulse rx_overrun_o.
- SHIFT, on sclk_fall:
  - If reload_pending, load tx_shift from buffer or DEFAULT_TX, using the same rules as IDLE.
  - Otherwise tx_shift <= tx_shift << 1.
- spi_miso_o = tx_shift[W-1] while selected, otherwise 1. spi_miso_oe_o = ~cs_sync (synchronized CS).
- cs_rise in SHIFT returns to IDLE at any bit_cnt. A partial frame is discarded: no rx_valid_o, bit_cnt=0, reload_pending cleared. A tx byte already loaded is consumed and not re-sent.
- rx handshake: rx_valid_o clears on a clk edge with rx_valid_o & rx_ready_i, unless a new byte completes in the same cycle, in which case rx_valid_o stays 1 with new data and no overrun.
- tx buffer write and byte load in the same cycle: the load sees the buffer contents before the write. If the buffer was empty, DEFAULT_TX is loaded (underrun pulses) and the written byte stays buffered for the next byte.
- Back-to-back frames: CS may stay low across bytes and framing continues seamlessly.
- rst_n low mid-frame aborts to the reset state on that edge.

Test Plan:
- Reset: hold rst_n=0 for 3 clk with CS_n=1 -> rx_valid_o=0, tx_ready_o=1, spi_miso_o=1, spi_miso_oe_o=0, busy_o=0.
- Single full-duplex byte: write tx 8'hA5, initiator sends 8'h3C at clk/8 -> MISO bits 1,0,1,0,0,1,0,1 sampled on rising edges; rx_data_o=8'h3C with rx_valid_o SYNC_STAGES+1 clk cycles after 8th rising edge; tx_ready_o=1 after cs_fall is seen.
- Underrun and continuous CS: no tx written, two bytes 8'h01, 8'h02 under one CS low -> MISO shows 8'hFF twice, tx_underrun_o pulses twice, two rx_valid_o events with rx_ready_i=1.
- Overrun: rx_ready_i=0, bytes 8'h11 then 8'h22 -> rx_overrun_o one pulse at second completion, rx_data_o=8'h22, rx_valid_o stays 1.
- Abort: CS_n rises after 5 bits -> no rx_valid_o, busy_o=0; next full frame 8'h5A received correctly.
- Simultaneous write and load: tx_valid_i asserted with 8'hC3 in the exact cycle cs_fall acts -> first byte 8'hFF with underrun pulse, second byte 8'hC3.
